// File: rtl/mem_store_unit.sv
// mem_store_unit: MEM-stage store path. Narrows a register value to a byte,
// halfword or word and replicates it across the byte lanes with matching
// strobes. Issues one write on an SRAM-like req/addr_ok/data_ok bus, and
// reports misaligned stores as an address error without touching the bus.
module mem_store_unit #(
    parameter int ADDR_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st_valid,
    output logic                 st_ready,
    input  logic [1:0]           st_size,
    input  logic [ADDR_BITS-1:0] st_addr,
    input  logic [31:0]          st_data,
    input  logic                 flush,
    output logic                 st_done,
    output logic                 ades,
    output logic [ADDR_BITS-1:0] badvaddr,
    output logic                 bus_err,
    output logic                 busy,
    output logic                 data_req,
    output logic                 data_wr,
    output logic [1:0]           data_size,
    output logic [ADDR_BITS-1:0] data_addr,
    output logic [31:0]          data_wdata,
    output logic [3:0]           data_wstrb,
    input  logic                 data_addr_ok,
    input  logic                 data_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Zero disables the timeout entirely.
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   data_req_q, data_req_d;
    logic [1:0]             data_size_q, data_size_d;
    logic [ADDR_BITS-1:0]   data_addr_q, data_addr_d;
    logic [31:0]            data_wdata_q, data_wdata_d;
    logic [3:0]             data_wstrb_q, data_wstrb_d;
    logic [ADDR_BITS-1:0]   badvaddr_q, badvaddr_d;
    logic                   st_done_q, st_done_d;
    logic                   ades_q, ades_d;
    logic                   bus_err_q, bus_err_d;

    logic                   accept;
    logic                   misaligned;
    logic [31:0]            lane_wdata;
    logic [3:0]             lane_wstrb;
    logic [31:0]            cnt_inc;
    logic                   timeout_hit;

    assign accept      = st_valid && (state_q == IDLE) && !flush;
    assign cnt_inc     = cnt_q + 32'd1;
    assign timeout_hit = (TIMEOUT_LIM != '0) && (cnt_inc == TIMEOUT_LIM);

    // Lane replication, byte strobes and alignment check for the incoming store
    always_comb begin
        lane_wdata = st_data;
        lane_wstrb = 4'b1111;
        misaligned = 1'b0;
        case (st_size)
            2'b00: begin
                lane_wdata = {4{st_data[7:0]}};
                lane_wstrb = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{st_data[15:0]}};
                lane_wstrb = 4'b0011 << st_addr[1:0];
                misaligned = st_addr[0];
            end
            2'b10: begin
                lane_wdata = st_data;
                lane_wstrb = 4'b1111;
                misaligned = (st_addr[1:0] != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Next-state logic: transaction sequencing, flush handling and timeout
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_req_d   = data_req_q;
        data_size_d  = data_size_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_wstrb_d = data_wstrb_q;
        badvaddr_d   = badvaddr_q;
        st_done_d    = 1'b0;
        ades_d       = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        ades_d     = 1'b1;
                        badvaddr_d = st_addr;
                    end else begin
                        state_d      = REQ;
                        data_req_d   = 1'b1;
                        cnt_d        = '0;
                        data_size_d  = st_size;
                        data_addr_d  = st_addr;
                        data_wdata_d = lane_wdata;
                        data_wstrb_d = lane_wstrb;
                    end
                end
            end
            REQ: begin
                // Address acceptance beats flush: once taken the write must finish.
                if (data_addr_ok) begin
                    state_d    = RESP;
                    data_req_d = 1'b0;
                    cnt_d      = '0;
                end else if (flush) begin
                    state_d    = IDLE;
                    data_req_d = 1'b0;
                    cnt_d      = '0;
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    data_req_d = 1'b0;
                    bus_err_d  = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP: begin
                if (data_data_ok) begin
                    state_d   = IDLE;
                    st_done_d = 1'b1;
                    cnt_d     = '0;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d    = IDLE;
                data_req_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_req_q   <= 1'b0;
            data_size_q  <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            data_wstrb_q <= '0;
            badvaddr_q   <= '0;
            st_done_q    <= 1'b0;
            ades_q       <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_req_q   <= data_req_d;
            data_size_q  <= data_size_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_wstrb_q <= data_wstrb_d;
            badvaddr_q   <= badvaddr_d;
            st_done_q    <= st_done_d;
            ades_q       <= ades_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign st_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign data_req   = data_req_q;
    assign data_wr    = data_req_q;
    assign data_size  = data_size_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;
    assign data_wstrb = data_wstrb_q;
    assign badvaddr   = badvaddr_q;
    assign st_done    = st_done_q;
    assign ades       = ades_q;
    assign bus_err    = bus_err_q;

endmodule
